// File: rtl/dram_port_scheduler_if.sv
// dram_port_scheduler_if: Avalon-MM bundle around the DRAM port scheduler.
// Carries the write master, read master, controller port and Grant.
// slave  : scheduler side (drives waits, read return, DRAM_*, Grant).
// master : masters and controller side (drives requests and DRAM returns).
interface dram_port_scheduler_if #(
   parameter int ADDR_W  = 25,
   parameter int DATA_W  = 256,
   parameter int BURST_W = 5
) ();

   logic               WR_Write;
   logic               WR_Burst_Begin;
   logic [BURST_W-1:0] WR_Burst_Count;
   logic [ADDR_W-1:0]  WR_Addr;
   logic [DATA_W-1:0]  WR_Data;
   logic               WR_Wait_Request;

   logic               RD_Read;
   logic [BURST_W-1:0] RD_Burst_Count;
   logic [ADDR_W-1:0]  RD_Addr;
   logic               RD_Wait_Request;
   logic [DATA_W-1:0]  RD_Data;
   logic               RD_Data_Valid;

   logic               DRAM_Wait_Request;
   logic               DRAM_Write;
   logic               DRAM_Read;
   logic               DRAM_Burst_Begin;
   logic [BURST_W-1:0] DRAM_Burst_Count;
   logic [ADDR_W-1:0]  DRAM_Addr;
   logic [DATA_W-1:0]  DRAM_Write_Data;
   logic [DATA_W-1:0]  DRAM_Read_Data;
   logic               DRAM_Read_Data_Valid;

   logic [1:0]         Grant;

   modport slave (
      input  WR_Write, WR_Burst_Begin, WR_Burst_Count,
      input  WR_Addr, WR_Data,
      input  RD_Read, RD_Burst_Count, RD_Addr,
      input  DRAM_Wait_Request, DRAM_Read_Data,
      input  DRAM_Read_Data_Valid,
      output WR_Wait_Request, RD_Wait_Request,
      output RD_Data, RD_Data_Valid,
      output DRAM_Write, DRAM_Read, DRAM_Burst_Begin,
      output DRAM_Burst_Count, DRAM_Addr, DRAM_Write_Data,
      output Grant
   );

   modport master (
      output WR_Write, WR_Burst_Begin, WR_Burst_Count,
      output WR_Addr, WR_Data,
      output RD_Read, RD_Burst_Count, RD_Addr,
      output DRAM_Wait_Request, DRAM_Read_Data,
      output DRAM_Read_Data_Valid,
      input  WR_Wait_Request, RD_Wait_Request,
      input  RD_Data, RD_Data_Valid,
      input  DRAM_Write, DRAM_Read, DRAM_Burst_Begin,
      input  DRAM_Burst_Count, DRAM_Addr, DRAM_Write_Data,
      input  Grant
   );

endinterface

// File: rtl/dram_port_scheduler.sv
// dram_port_scheduler: shares one DRAM Avalon-MM port between the
// write-only event drain and the read-only trigger readout, per burst.
// Ports: clk, rst_n (async, active low), bus (dram_port_scheduler_if.slave)
//   WR_*   write master in, WR_Wait_Request out
//   RD_*   read command in, RD_Wait_Request / RD_Data / RD_Data_Valid out
//   DRAM_* controller port, Grant out (00 none, 01 write, 10 read)
// Option: define DRAM_SCHED_RD_STARVE_EN to let a read that has waited
//   STARVE_LIMIT cycles win over a requesting write; otherwise writes
//   have strict priority.
module dram_port_scheduler #(
   parameter int ADDR_W             = 25,
   parameter int DATA_W             = 256,
   parameter int BURST_W            = 5,
   parameter int STARVE_LIMIT       = 64,
   parameter int MAX_RD_OUTSTANDING = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dram_port_scheduler_if.slave  bus
);

   localparam int OUT_W = $clog2(MAX_RD_OUTSTANDING + 1);
   localparam logic [BURST_W:0] ONE_B = 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WR_BURST = 2'd1,
      S_RD_CMD   = 2'd2
   } state_t;

   state_t             r_state;
   logic [1:0]         r_grant;
   logic [BURST_W:0]   r_beats_left;
   logic [OUT_W-1:0]   r_rd_out;
   logic [DATA_W-1:0]  r_rd_data;
   logic               r_rd_valid;

   logic [BURST_W:0]   w_wr_len;
   logic [BURST_W:0]   w_rd_len;
   logic [31:0]        w_rd_sum;
   logic               w_wr_req;
   logic               w_rd_elig;
   logic               w_rd_win;
   logic               w_wr_acc;
   logic               w_rd_acc;
   logic               w_starve_hit;
   logic [OUT_W-1:0]   w_out_add;
   logic [OUT_W-1:0]   w_out_sub;

   logic               w_dram_write;
   logic               w_dram_read;
   logic               w_dram_bb;
   logic [BURST_W-1:0] w_dram_cnt;
   logic [ADDR_W-1:0]  w_dram_addr;
   logic [DATA_W-1:0]  w_dram_wdata;
   logic               w_wr_wait;
   logic               w_rd_wait;

   // A burst count of zero is a one-beat burst.
   assign w_wr_len = (bus.WR_Burst_Count == '0) ? ONE_B
                   : {1'b0, bus.WR_Burst_Count};
   assign w_rd_len = (bus.RD_Burst_Count == '0) ? ONE_B
                   : {1'b0, bus.RD_Burst_Count};

   assign w_wr_req  = bus.WR_Write & bus.WR_Burst_Begin;
   assign w_rd_sum  = 32'(r_rd_out) + 32'(w_rd_len);
   assign w_rd_elig = bus.RD_Read
                    & (w_rd_sum <= 32'(MAX_RD_OUTSTANDING));
   assign w_rd_win  = w_rd_elig & (~w_wr_req | w_starve_hit);

   assign w_wr_acc = (r_state == S_WR_BURST) & bus.WR_Write
                   & ~bus.DRAM_Wait_Request;
   assign w_rd_acc = (r_state == S_RD_CMD) & bus.RD_Read
                   & ~bus.DRAM_Wait_Request;

   // Acceptance and return in one cycle net out in a single update.
   assign w_out_add = w_rd_acc ? OUT_W'(w_rd_len) : '0;
   assign w_out_sub = OUT_W'(bus.DRAM_Read_Data_Valid);

`ifdef DRAM_SCHED_RD_STARVE_EN
   localparam int ST_W = $clog2(STARVE_LIMIT + 2);
   localparam logic [ST_W-1:0] ST_ONE = 1;
   localparam logic [ST_W-1:0] ST_MAX = ST_W'(STARVE_LIMIT);

   logic [ST_W-1:0] r_starve_cnt;

   assign w_starve_hit = (r_starve_cnt >= ST_MAX);

   // Counts waiting cycles of a pending read; saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (!bus.RD_Read || w_rd_acc) begin
         r_starve_cnt <= '0;
      end else if (r_state != S_RD_CMD && !w_starve_hit) begin
         r_starve_cnt <= r_starve_cnt + ST_ONE;
      end
   end
`else
   // Strict write priority: the override never fires.
   assign w_starve_hit = (STARVE_LIMIT < 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_grant      <= 2'b00;
         r_beats_left <= '0;
         r_rd_out     <= '0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_rd_data  <= bus.DRAM_Read_Data;
         r_rd_valid <= bus.DRAM_Read_Data_Valid;
         r_rd_out   <= r_rd_out + w_out_add - w_out_sub;
         unique case (r_state)
            S_IDLE: begin
               if (w_rd_win) begin
                  r_state <= S_RD_CMD;
                  r_grant <= 2'b10;
               end else if (w_wr_req) begin
                  r_state      <= S_WR_BURST;
                  r_grant      <= 2'b01;
                  r_beats_left <= w_wr_len;
               end
            end
            S_WR_BURST: begin
               if (w_wr_acc) begin
                  r_beats_left <= r_beats_left - ONE_B;
                  if (r_beats_left == ONE_B) begin
                     r_state <= S_IDLE;
                     r_grant <= 2'b00;
                  end
               end
            end
            S_RD_CMD: begin
               // Leave on acceptance or when the read is withdrawn.
               if (w_rd_acc || !bus.RD_Read) begin
                  r_state <= S_IDLE;
                  r_grant <= 2'b00;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   // Port routing follows the registered owner, so an async reset
   // drops every strobe in the same cycle.
   always_comb begin
      w_dram_write = 1'b0;
      w_dram_read  = 1'b0;
      w_dram_bb    = 1'b0;
      w_dram_cnt   = '0;
      w_dram_addr  = '0;
      w_dram_wdata = '0;
      w_wr_wait    = 1'b1;
      w_rd_wait    = 1'b1;
      unique case (1'b1)
         (r_state == S_WR_BURST): begin
            w_dram_write = bus.WR_Write;
            w_dram_bb    = bus.WR_Burst_Begin;
            w_dram_cnt   = bus.WR_Burst_Count;
            w_dram_addr  = bus.WR_Addr;
            w_dram_wdata = bus.WR_Data;
            w_wr_wait    = bus.DRAM_Wait_Request;
         end
         (r_state == S_RD_CMD): begin
            w_dram_read = bus.RD_Read;
            w_dram_bb   = bus.RD_Read;
            w_dram_cnt  = bus.RD_Burst_Count;
            w_dram_addr = bus.RD_Addr;
            w_rd_wait   = bus.DRAM_Wait_Request;
         end
         default: begin
         end
      endcase
   end

   assign bus.DRAM_Write       = w_dram_write;
   assign bus.DRAM_Read        = w_dram_read;
   assign bus.DRAM_Burst_Begin = w_dram_bb;
   assign bus.DRAM_Burst_Count = w_dram_cnt;
   assign bus.DRAM_Addr        = w_dram_addr;
   assign bus.DRAM_Write_Data  = w_dram_wdata;
   assign bus.WR_Wait_Request  = w_wr_wait;
   assign bus.RD_Wait_Request  = w_rd_wait;
   assign bus.RD_Data          = r_rd_data;
   assign bus.RD_Data_Valid    = r_rd_valid;
   assign bus.Grant            = r_grant;

endmodule

// File: tb/tb_dram_port_scheduler.sv
// tb_dram_port_scheduler: directed bench for dram_port_scheduler.
// Acts as write master, read master and DRAM controller.
module tb_dram_port_scheduler;

   localparam int AW = 25;
   localparam int DW = 256;
   localparam int BW = 5;
   localparam int SL = 8;
   localparam int MO = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dram_port_scheduler_if #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)
   ) bus ();

   dram_port_scheduler #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW),
      .STARVE_LIMIT(SL), .MAX_RD_OUTSTANDING(MO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int n_chk = 0;
   int n_err = 0;

   int wq_d[$];
   int wq_c[$];
   int wq_g[$];
   int rq[$];

   int c0, s, r0, acc, a1, a2, a3;
   bit stop;

   always @(negedge clk) begin
      if (bus.DRAM_Write && !bus.DRAM_Wait_Request) begin
         wq_d.push_back(int'(bus.DRAM_Write_Data[31:0]));
         wq_c.push_back(cyc);
         wq_g.push_back(int'(bus.Grant));
      end
      if (bus.RD_Data_Valid)
         rq.push_back(int'(bus.RD_Data[31:0]));
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_burst(input int n, input int a, input int base,
                           input int stall);
      for (int i = 0; i < n; i++) begin
         bus.WR_Write       = 1'b1;
         bus.WR_Burst_Begin = (i == 0);
         bus.WR_Burst_Count = BW'(n);
         bus.WR_Addr        = AW'(a);
         bus.WR_Data        = DW'(base + i);
         if (stall[i]) begin
            bus.DRAM_Wait_Request = 1'b1;
            @(negedge clk);
            check("wr_stall_wait", bus.WR_Wait_Request, 1);
            step();
            bus.DRAM_Wait_Request = 1'b0;
         end
         @(negedge clk);
         for (int t = 0; t < 40 && bus.WR_Wait_Request; t++)
            @(negedge clk);
         if (bus.WR_Wait_Request)
            check("wr_timeout", bus.WR_Wait_Request, 0);
         step();
      end
      bus.WR_Write       = 1'b0;
      bus.WR_Burst_Begin = 1'b0;
   endtask

   task automatic rd_cmd(input int n, input int a, input int tmo,
                         output int ac);
      ac = -1;
      bus.RD_Read        = 1'b1;
      bus.RD_Burst_Count = BW'(n);
      bus.RD_Addr        = AW'(a);
      @(negedge clk);
      for (int t = 0; t < tmo && bus.RD_Wait_Request; t++)
         @(negedge clk);
      if (!bus.RD_Wait_Request) begin
         ac = cyc;
         check("rd_cmd_strobe", bus.DRAM_Read, 1);
         check("rd_cmd_addr", bus.DRAM_Addr, a);
         check("rd_cmd_grant", bus.Grant, 2);
      end
      step();
      bus.RD_Read = 1'b0;
   endtask

   task automatic rd_ret(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         bus.DRAM_Read_Data_Valid = 1'b1;
         bus.DRAM_Read_Data       = DW'(base + i);
         step();
      end
      bus.DRAM_Read_Data_Valid = 1'b0;
   endtask

   initial begin
      bus.WR_Write             = 1'b0;
      bus.WR_Burst_Begin       = 1'b0;
      bus.WR_Burst_Count       = '0;
      bus.WR_Addr              = '0;
      bus.WR_Data              = '0;
      bus.RD_Read              = 1'b0;
      bus.RD_Burst_Count       = '0;
      bus.RD_Addr              = '0;
      bus.DRAM_Wait_Request    = 1'b0;
      bus.DRAM_Read_Data       = '0;
      bus.DRAM_Read_Data_Valid = 1'b0;
      stop = 1'b0;

      // reset state
      repeat (2) step();
      check("rst_wr_wait", bus.WR_Wait_Request, 1);
      check("rst_rd_wait", bus.RD_Wait_Request, 1);
      check("rst_grant", bus.Grant, 0);
      check("rst_dram_wr", bus.DRAM_Write, 0);
      check("rst_dram_rd", bus.DRAM_Read, 0);
      check("rst_dram_bb", bus.DRAM_Burst_Begin, 0);
      check("rst_rd_valid", bus.RD_Data_Valid, 0);
      rst_n = 1'b1;
      step();

      // single 8-beat write, no stalls
      wq_d.delete(); wq_c.delete(); wq_g.delete();
      c0 = cyc;
      wr_burst(8, 'h100, 'h1000, 0);
      @(negedge clk);
      check("wr1_end_grant", bus.Grant, 0);
      check("wr1_beats", wq_d.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("wr1_data%0d", i), wq_d[i], 'h1000 + i);
         check($sformatf("wr1_cyc%0d", i), wq_c[i], c0 + 1 + i);
         check($sformatf("wr1_grant%0d", i), wq_g[i], 1);
      end
      step();

      // 8-beat write, controller stalls beats 3 and 5
      wq_d.delete(); wq_c.delete(); wq_g.delete();
      c0 = cyc;
      wr_burst(8, 'h180, 'h2000, 'b10100);
      step();
      check("bp_beats", wq_d.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_data%0d", i), wq_d[i], 'h2000 + i);
         check($sformatf("bp_cyc%0d", i), wq_c[i],
               c0 + 1 + i + (i >= 2 ? 1 : 0) + (i >= 4 ? 1 : 0));
      end

      // reset in the middle of a write burst
      bus.WR_Write       = 1'b1;
      bus.WR_Burst_Begin = 1'b1;
      bus.WR_Burst_Count = BW'(8);
      bus.WR_Addr        = AW'('h1c0);
      bus.WR_Data        = DW'('h3000);
      step();
      @(negedge clk);
      check("mid_grant_before", bus.Grant, 1);
      step();
      bus.WR_Burst_Begin = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_dram_wr", bus.DRAM_Write, 0);
      check("mid_rst_dram_bb", bus.DRAM_Burst_Begin, 0);
      check("mid_rst_grant", bus.Grant, 0);
      check("mid_rst_wr_wait", bus.WR_Wait_Request, 1);
      bus.WR_Write = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // simultaneous write and read requests
      wq_d.delete(); wq_c.delete(); wq_g.delete(); rq.delete();
      c0 = cyc;
      fork
         wr_burst(4, 'h200, 'h4000, 0);
         rd_cmd(4, 'h300, 30, acc);
      join
      check("sim_wr_first", wq_c[0], c0 + 1);
      check("sim_wr_last", wq_c[3], c0 + 4);
      check("sim_rd_acc", acc, c0 + 6);

      // read return latency and data
      bus.DRAM_Read_Data_Valid = 1'b1;
      bus.DRAM_Read_Data       = DW'('h5000);
      @(negedge clk);
      check("lat_pre_valid", bus.RD_Data_Valid, 0);
      step();
      @(negedge clk);
      check("lat_valid", bus.RD_Data_Valid, 1);
      check("lat_data", bus.RD_Data[31:0], 'h5000);
      rd_ret(3, 'h5001);
      step();
      check("ret_count", rq.size(), 4);
      check("ret_last", rq[3], 'h5003);
      check("ret_out_zero", dut.r_rd_out, 0);

      // pending read against back-to-back single-beat writes
      s = cyc;
      stop = 1'b0;
`ifdef DRAM_SCHED_RD_STARVE_EN
      fork
         for (int b = 0; b < 12 && !stop; b++)
            wr_burst(1, 'h400 + b, 'h6000 + b, 0);
         begin
            rd_cmd(1, 'h500, 40, acc);
            stop = 1'b1;
         end
      join
      check("starve_acc", acc, s + SL + 1);
      check("starve_bound", (acc >= 0) && (acc - s <= SL + 2), 1);
`else
      fork
         for (int b = 0; b < 12; b++)
            wr_burst(1, 'h400 + b, 'h6000 + b, 0);
         rd_cmd(1, 'h500, 20, acc);
      join
      check("strict_no_grant", acc, -1);
      s = cyc;
      rd_cmd(1, 'h500, 10, acc);
      check("strict_rd_after", acc, s + 1);
`endif
      rd_ret(1, 'h7000);
      step();

      // outstanding read limit
      rq.delete();
      rd_cmd(16, 'h600, 10, a1);
      rd_cmd(16, 'h610, 10, a2);
      check("out_rd1_acc", a1 >= 0, 1);
      check("out_rd2_acc", a2 >= 0, 1);
      fork
         rd_cmd(16, 'h620, 60, a3);
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check($sformatf("out_stall%0d", k), bus.RD_Wait_Request, 1);
               step();
            end
            r0 = cyc;
            rd_ret(16, 'h8000);
         end
      join
      check("out_rd3_acc", a3, r0 + 17);
      rd_ret(32, 'h9000);
      step();
      check("out_ret_count", rq.size(), 48);
      check("out_ret0", rq[0], 'h8000);
      check("out_ret15", rq[15], 'h800f);
      check("out_ret16", rq[16], 'h9000);
      check("out_ret47", rq[47], 'h901f);
      check("out_final_zero", dut.r_rd_out, 0);
      check("end_grant", bus.Grant, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dram_port_scheduler.md
# dram_port_scheduler

Shares the single DRAM controller Avalon-MM port between the event write path (reorder-buffer drain, write-only bursts) and the trigger readout path (read-only bursts). Arbitrates per burst, holds the grant until the burst completes, and returns read data to the readout path. The readout path has a bounded number of outstanding read beats. Write traffic has priority so that front-end buffers never overflow; a starvation guard bounds read latency.

## Interface
- `ADDR_W`, default 25: DRAM word address width.
- `DATA_W`, default 256: DRAM data width.
- `BURST_W`, default 5: burst count width.
- `STARVE_LIMIT`, default 64: cycles a pending read may wait before it overrides write priority.
- `MAX_RD_OUTSTANDING`, default 32: maximum read beats requested but not yet returned.
- `clk` in, 1: the single clock.
- `rst_n` in, 1: asynchronous active-low reset.
- `WR_Write` in, 1: write master drives a beat.
- `WR_Burst_Begin` in, 1: first beat of a write burst.
- `WR_Burst_Count` in, BURST_W: write burst length in beats. The value 0 is treated as 1.
- `WR_Addr` in, ADDR_W: write burst start address.
- `WR_Data` in, DATA_W: write beat data.
- `WR_Wait_Request` out, 1: high means the write beat was not accepted.
- `RD_Read` in, 1: read command request.
- `RD_Burst_Count` in, BURST_W: read burst length. The value 0 is treated as 1.
- `RD_Addr` in, ADDR_W: read burst start address.
- `RD_Wait_Request` out, 1: high means the read command was not accepted.
- `RD_Data` out, DATA_W: returned read data.
- `RD_Data_Valid` out, 1: `RD_Data` is valid this cycle.
- `DRAM_Wait_Request` in, 1: controller stall. High means the current command or beat was not accepted.
- `DRAM_Write` out, 1: write strobe to the controller.
- `DRAM_Read` out, 1: read strobe to the controller.
- `DRAM_Burst_Begin` out, 1: burst begin to the controller.
- `DRAM_Burst_Count` out, BURST_W: burst count to the controller.
- `DRAM_Addr` out, ADDR_W: address to the controller.
- `DRAM_Write_Data` out, DATA_W: write data to the controller.
- `DRAM_Read_Data` in, DATA_W: read data from the controller.
- `DRAM_Read_Data_Valid` in, 1: read data valid from the controller.
- `Grant` out, 2: current owner. 00 = none, 01 = write, 10 = read.

## Operation
- **States:** IDLE, WR_BURST, RD_CMD.
- **IDLE:**
  - Outputs are not routed to any master. `WR_Wait_Request` = `RD_Wait_Request` = 1.
  - A write request is `WR_Write & WR_Burst_Begin`.
  - A read request is `RD_Read`, and is eligible only if `rd_outstanding` + len ≤ MAX_RD_OUTSTANDING.
  - Winner: the read if it is eligible and either no write is requesting or `starve_cnt` ≥ STARVE_LIMIT. Otherwise the write if it is requesting.
  - Write winner: load `beats_left` ← len and go to WR_BURST. Read winner: go to RD_CMD.
- **WR_BURST:**
  - `DRAM_*` command and data signals equal the `WR_*` inputs. `DRAM_Read` = 0. `WR_Wait_Request` = `DRAM_Wait_Request`.
  - An accepted beat is `WR_Write & !DRAM_Wait_Request`. Each accepted beat decrements `beats_left`.
  - When the beat with `beats_left` == 1 is accepted, go to IDLE.
- **RD_CMD:**
  - `DRAM_Read` = `RD_Read`. Address and count come from `RD_*`. `DRAM_Burst_Begin` = `RD_Read`. `RD_Wait_Request` = `DRAM_Wait_Request`.
  - On acceptance (`RD_Read & !DRAM_Wait_Request`): `rd_outstanding` += len, then go to IDLE.
  - If `RD_Read` drops before acceptance, go to IDLE with nothing added.
- **Read return:**
  - `RD_Data` and `RD_Data_Valid` are registered copies of the `DRAM_Read_*` inputs, in every state.
  - Each valid beat decrements `rd_outstanding`.
  - Read returns may overlap a write burst.
  - An acceptance and a return in the same cycle update `rd_outstanding` by the net amount.
- **`starve_cnt`:**
  - Increments each cycle `RD_Read` is high and the state is not RD_CMD. It saturates at STARVE_LIMIT.
  - It clears on read acceptance or when `RD_Read` is low.
- **Widths:** `rd_outstanding` is wide enough to hold MAX_RD_OUTSTANDING. `beats_left` is BURST_W+1 bits.

## Timing
- Arbitration costs one cycle. The request is seen in IDLE, and the first beat is routed in the following cycle.
- The granted master must hold its command until `Wait_Request` is low.
- Write throughput inside a burst is one beat per cycle.
- Read data latency through the block is one cycle.
- There is always at least one IDLE cycle between consecutive bursts.
- **Reset:** all outputs are 0 except `WR_Wait_Request` = `RD_Wait_Request` = 1 and `Grant` = 00. State goes to IDLE and all counters clear.
- **Reset mid-burst:** the burst is abandoned. The masters must restart after reset.

## Configuration
- `DRAM_SCHED_RD_STARVE_EN`: defined, the starvation override above is active.
- Undefined: `starve_cnt` is not built. Writes have strict priority, and a read wins only when no write is requesting.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-WR_BURST → all `DRAM_*` strobes are 0, `Grant` = 00, `WR_Wait_Request` = 1 on the same cycle.
- **Single write burst:** one 8-beat write with `DRAM_Wait_Request` low → 8 beats appear on `DRAM_Write` in 8 consecutive cycles starting one cycle after the request, `Grant` = 01, then IDLE.
- **Backpressure:** same 8-beat write with `DRAM_Wait_Request` high on beats 3 and 5 → beats are held and all 8 are accepted over 10 cycles, in order, with unchanged data.
- **Simultaneous requests:** write and read requested in the same cycle with `starve_cnt` = 0 → write granted first; read granted after the write burst ends.
- **Starvation (macro defined):** continuous back-to-back writes plus a pending read → read granted within STARVE_LIMIT + 2 cycles. Macro undefined → read is never granted while writes persist.
- **Outstanding limit:** two 16-beat reads accepted with data withheld → a third read stalls with `RD_Wait_Request` = 1. After 16 returned beats, the third read is granted; `rd_outstanding` ends at 0 once all data has returned.
